// File: rtl/data_pack_pkg.sv
// Shared constants and types for the 7-to-32 symbol packer.
package data_pack_pkg;

    localparam int DEF_IN_WIDTH  = 7;
    localparam int DEF_OUT_WIDTH = 32;
    localparam int BITS_W        = $clog2(DEF_OUT_WIDTH) + 1;

    function automatic int acc_width(input int in_w, input int out_w);
        return out_w + in_w - 1;
    endfunction

    localparam int ACC_W = acc_width(DEF_IN_WIDTH, DEF_OUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        FLUSH
    } state_t;

endpackage

// File: rtl/data_pack_gearbox.sv
// Shift-append accumulator: symbols land at acc[cnt +: IN_WIDTH], full words leave from the bottom.
module pack_gearbox
    import data_pack_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  append,
    input  logic                  emit,
    input  logic [IN_WIDTH-1:0]   data,
    output logic [OUT_WIDTH-1:0]  word,
    output logic [BITS_W-1:0]     fill,
    output logic                  word_ready,
    output logic [BITS_W-2:0]     leftover
);

    localparam int ACC_WL = acc_width(IN_WIDTH, OUT_WIDTH);

    logic [ACC_WL-1:0] acc;
    logic [ACC_WL-1:0] base_acc;
    logic [ACC_WL-1:0] merged;
    logic [BITS_W-2:0] cnt;
    logic [BITS_W-2:0] base_cnt;
    logic [BITS_W-1:0] fill_c;

    // clear drops the old contents first, so a clear+append starts a fresh word at bit 0
    always_comb begin
        base_acc = clear ? '0 : acc;
        base_cnt = clear ? '0 : cnt;
        merged   = base_acc;
        fill_c   = {1'b0, base_cnt};
        if (append) begin
            merged = base_acc | (ACC_WL'(data) << base_cnt);
            fill_c = {1'b0, base_cnt} + BITS_W'(IN_WIDTH);
        end
    end

    assign word       = merged[OUT_WIDTH-1:0];
    assign fill       = fill_c;
    assign word_ready = (fill_c >= BITS_W'(OUT_WIDTH));
    assign leftover   = word_ready ? (BITS_W-1)'(fill_c - BITS_W'(OUT_WIDTH)) : '0;

    // bits above fill are always zero, so emitting a short word also empties the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (emit) begin
            acc <= merged >> OUT_WIDTH;
            cnt <= leftover;
        end else if (append || clear) begin
            acc <= merged;
            cnt <= fill_c[BITS_W-2:0];
        end
    end

endmodule

// File: rtl/data_pack.sv
// Packs sop/eop-framed 7-bit symbols LSB-first into 32-bit words with a one-deep output register.
//   state | meaning
//   IDLE  | no packet open; only a sop symbol is taken
//   PACK  | packet open, symbols appended to the gearbox
//   FLUSH | eop overflowed a word; leftover bits wait for the output slot
module data_pack
    import data_pack_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [IN_WIDTH-1:0]   data_in,
    input  logic                  sop_in,
    input  logic                  eop_in,
    output logic                  ready_out,
    output logic                  valid_out,
    output logic [OUT_WIDTH-1:0]  data_out,
    output logic                  sop_out,
    output logic                  eop_out,
    output logic [BITS_W-1:0]     bits_out,
    input  logic                  ready_in,
    output logic                  drop_out
);

    state_t state;
    logic   pend_sop;

    logic                 slot_free;
    logic                 accept;
    logic                 take;
    logic                 load_pack;
    logic                 load_flush;
    logic                 overflow;
    logic [OUT_WIDTH-1:0] gb_word;
    logic [BITS_W-1:0]    gb_fill;
    logic                 gb_word_ready;
    logic [BITS_W-2:0]    gb_leftover;

    assign slot_free  = ~valid_out | ready_in;
    assign ready_out  = (state != FLUSH) & slot_free;
    assign accept     = valid_in & ready_out;
    assign take       = accept & ((state == PACK) | sop_in);
    assign load_pack  = take & (eop_in | gb_word_ready);
    assign load_flush = (state == FLUSH) & slot_free;
    assign overflow   = gb_word_ready & (gb_leftover != '0);

    pack_gearbox #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_gearbox (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept & sop_in),
        .append     (take),
        .emit       (load_pack | load_flush),
        .data       (data_in),
        .word       (gb_word),
        .fill       (gb_fill),
        .word_ready (gb_word_ready),
        .leftover   (gb_leftover)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_sop  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            bits_out  <= '0;
            drop_out  <= 1'b0;
        end else begin
            drop_out <= accept & sop_in & (state == PACK);

            if (valid_out & ready_in)
                valid_out <= 1'b0;

            if (load_pack) begin
                valid_out <= 1'b1;
                data_out  <= gb_word;
                sop_out   <= sop_in | pend_sop;
                eop_out   <= eop_in & ~overflow;
                bits_out  <= gb_word_ready ? BITS_W'(OUT_WIDTH) : gb_fill;
            end else if (load_flush) begin
                valid_out <= 1'b1;
                data_out  <= gb_word;
                sop_out   <= 1'b0;
                eop_out   <= 1'b1;
                bits_out  <= gb_fill;
            end

            // sop is owed to the first word loaded after the packet (re)opens
            if (load_pack)
                pend_sop <= 1'b0;
            else if (take & sop_in)
                pend_sop <= 1'b1;

            case (state)
                IDLE:    if (take) state <= eop_in ? IDLE : PACK;
                PACK:    if (take & eop_in) state <= overflow ? FLUSH : IDLE;
                FLUSH:   if (slot_free) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_pack.sv
// Scoreboarded bench for data_pack: a bit-queue reference model feeds expected words, a monitor pops them.
module tb_data_pack;
    import data_pack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [6:0]  data_in = '0;
    logic        sop_in = 1'b0;
    logic        eop_in = 1'b0;
    logic        ready_in = 1'b1;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] data_out;
    logic        sop_out;
    logic        eop_out;
    logic [5:0]  bits_out;
    logic        drop_out;

    data_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .bits_out  (bits_out),
        .ready_in  (ready_in),
        .drop_out  (drop_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [5:0]  bits;
    } word_t;

    word_t exp_q[$];
    word_t mw;
    bit    bq[$];
    bit    in_pkt = 0;
    bit    first_word = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    exp_drops = 0;
    int    drops_seen = 0;
    int    stall_cycles = 0;
    int    rdy_mode = 0;
    int    s0;
    int    len;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_emit(input int nb, input bit eop);
        word_t w;
        w.data = '0;
        for (int i = 0; i < nb; i++) w.data[i] = bq.pop_front();
        w.sop  = first_word;
        w.eop  = eop;
        w.bits = 6'(nb);
        exp_q.push_back(w);
        first_word = 0;
    endtask

    task automatic model_accept(input logic [6:0] d, input logic s, input logic e);
        if (s) begin
            if (in_pkt) exp_drops++;
            bq.delete();
            in_pkt = 1;
            first_word = 1;
        end
        if (!in_pkt) return;
        for (int i = 0; i < 7; i++) bq.push_back(d[i]);
        if (e) begin
            if (bq.size() > 32) model_emit(32, 0);
            model_emit(bq.size(), 1);
            in_pkt = 0;
        end else if (bq.size() >= 32) begin
            model_emit(32, 0);
        end
    endtask

    task automatic send(input logic [6:0] d, input logic s, input logic e);
        int tries = 0;
        bit done = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        while (!done) begin
            #1;
            if (ready_out) begin
                @(posedge clk);
                model_accept(d, s, e);
                done = 1;
            end else begin
                tries++;
                stall_cycles++;
                if (tries > 200) begin
                    chk("accept_timeout", 1, 0);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || valid_out); i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic send_five(input logic eop_last);
        send(7'h01, 1, 0);
        send(7'h02, 0, 0);
        send(7'h03, 0, 0);
        send(7'h04, 0, 0);
        send(7'h05, 0, eop_last);
    endtask

    initial forever begin
        @(negedge clk);
        case (rdy_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = 1'b0;
            default: ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    // sampled just before the next rising edge, after inputs have settled
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (drop_out) drops_seen++;
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    mw = exp_q.pop_front();
                    chk("word_data", data_out, mw.data);
                    chk("word_sop", sop_out, mw.sop);
                    chk("word_eop", eop_out, mw.eop);
                    chk("word_bits", bits_out, mw.bits);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_sop", sop_out, 0);
        chk("rst_eop", eop_out, 0);
        chk("rst_bits", bits_out, 0);
        chk("rst_drop", drop_out, 0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", ready_out, 1);

        // five symbols: full word then a 3-bit eop word via FLUSH
        send_five(1);
        @(negedge clk); #1;
        chk("t1_word", data_out, 32'h5080C101);
        chk("t1_bits", bits_out, 32);
        chk("t1_sop", sop_out, 1);
        chk("t1_flush_ready", ready_out, 0);
        @(negedge clk); #1;
        chk("t1_tail_data", data_out, 0);
        chk("t1_tail_bits", bits_out, 3);
        chk("t1_tail_eop", eop_out, 1);
        chk("t1_ready_back", ready_out, 1);
        drain();

        send(7'h7F, 1, 1);
        @(negedge clk); #1;
        chk("t2_data", data_out, 32'h0000007F);
        chk("t2_bits", bits_out, 7);
        chk("t2_sop", sop_out, 1);
        chk("t2_eop", eop_out, 1);
        drain();

        s0 = stall_cycles;
        for (int i = 0; i < 32; i++) send(7'(i + 1), i == 0, i == 31);
        chk("t3_no_stall", stall_cycles - s0, 0);
        @(negedge clk); #1;
        chk("t3_last_eop", eop_out, 1);
        chk("t3_last_bits", bits_out, 32);
        chk("t3_no_flush", ready_out, 1);
        drain();

        // downstream stall with a word pending
        rdy_mode = 1;
        send_five(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) chk("t4_pending", 0, 1);
            else chk("t4_hold_data", data_out, exp_q[0].data);
            chk("t4_ready_low", ready_out, 0);
        end
        rdy_mode = 0;
        send(7'h06, 0, 1);
        drain();

        // sop mid-packet restarts, stray symbol in IDLE is ignored
        send(7'h0A, 1, 0);
        send(7'h0B, 0, 0);
        send(7'h0C, 0, 0);
        send(7'h11, 1, 0);
        send(7'h22, 0, 1);
        @(negedge clk); #1;
        chk("t5_restart_data", data_out, 32'h00001111);
        chk("t5_restart_sop", sop_out, 1);
        drain();
        chk("t5_drops", drops_seen, exp_drops);
        send(7'h55, 0, 0);
        send(7'h01, 1, 1);
        @(negedge clk); #1;
        chk("t5_stray_data", data_out, 32'h00000001);
        drain();

        // asynchronous reset with a word held in the output register
        rdy_mode = 1;
        send_five(0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", valid_out, 0);
        chk("t6_data", data_out, 0);
        chk("t6_sop", sop_out, 0);
        chk("t6_eop", eop_out, 0);
        chk("t6_bits", bits_out, 0);
        chk("t6_drop", drop_out, 0);
        exp_q.delete();
        bq.delete();
        in_pkt = 0;
        repeat (2) @(negedge clk);
        rdy_mode = 0;
        rst_n = 1'b1;
        #1;
        chk("t6_ready", ready_out, 1);
        send_five(1);
        @(negedge clk); #1;
        chk("t6_repack", data_out, 32'h5080C101);
        drain();

        rdy_mode = 2;
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) send(7'($urandom), i == 0, i == len - 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();
        repeat (3) @(negedge clk);
        chk("drops_total", drops_seen, exp_drops);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_pack.md
# data_pack

Packs a stream of 7-bit symbols, framed by sop/eop, into a bit-continuous stream of 32-bit words, LSB-first, with one flag for the first word of each packet (sop) and one for the last (eop). It is the transmit-side counterpart of the 32-to-7 unpacker and sits between the symbol source and the 32-bit word link. The last word of a packet is zero-padded, and a bit count reports how many of its bits are meaningful. Downstream back-pressure is honoured through a valid/ready handshake.

## Interface
- IN_WIDTH, 7, symbol width in bits
- OUT_WIDTH, 32, output word width in bits
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  symbol valid
- data_in  in  IN_WIDTH  symbol; bit 0 goes first on the bit stream
- sop_in  in  1  first symbol of packet
- eop_in  in  1  last symbol of packet
- ready_out  out  1  block can accept a symbol this cycle
- valid_out  out  1  output word valid
- data_out  out  OUT_WIDTH  packed word
- sop_out  out  1  first word of packet
- eop_out  out  1  last word of packet
- bits_out  out  6  valid bits in data_out (1..32); 32 on every word except the eop word
- ready_in  in  1  downstream accepts the word
- drop_out  out  1  one-cycle pulse when partial packet bits are discarded

## Operation
- A symbol is accepted when valid_in & ready_out; a word is transferred when valid_out & ready_in.
- Accumulator acc (38 bits) and count cnt (0..31); each accepted symbol is written at acc[cnt +: 7].
- State IDLE (no packet open), when a symbol is accepted:
  - sop_in=1 opens the packet and moves to PACK.
  - sop_in=0 discards the symbol, with no drop_out pulse.
- State PACK, when a symbol is accepted, let n = cnt + 7:
  - n ≥ 32 and eop_in=0: load acc[31:0] into the output register with bits_out=32; acc shifts right by 32; cnt = n − 32.
  - eop_in=1 and n ≤ 32: load the zero-padded word with bits_out=n and eop_out=1; cnt=0; go to IDLE.
  - eop_in=1 and n > 32: load the full word (bits_out=32, eop_out=0); go to FLUSH holding the n − 32 leftover bits.
- State FLUSH: ready_out=0. When the output slot frees, load the leftover word (zero-padded, bits_out = leftover count, eop_out=1); cnt=0; go to IDLE.
- sop_out=1 on the first word loaded after the packet opens.
- Single-symbol packet (sop_in & eop_in in IDLE): one word with sop_out=1, eop_out=1, bits_out=7.
- sop_in while in PACK: discard the accumulated bits and pulse drop_out. Restart the packet with this symbol, so the next word carries sop_out.
- ready_out = (state != FLUSH) & (~valid_out | ready_in).

## Timing
- Reset values: valid_out=0, data_out=0, sop_out=0, eop_out=0, bits_out=0, drop_out=0, cnt=0, state=IDLE.
- ready_out is 1 from the first cycle after reset deasserts.
- Latency: a symbol accepted in cycle N that completes a word gives valid_out=1 in cycle N+1.
- The output register holds data_out, sop_out, eop_out and bits_out stable while valid_out & ~ready_in.
- The output register can load in the same cycle a transfer occurs, so sustained throughput is 1 symbol per cycle with ready_in held high.
- FLUSH lasts at least 1 cycle, and longer while downstream stalls.
- Asserting rst_n low mid-packet clears everything immediately; the partial packet is lost and drop_out is not pulsed.

## Structure
- data_pack_pkg holds:
  - IN_WIDTH and OUT_WIDTH defaults
  - ACC_W = OUT_WIDTH + IN_WIDTH − 1
  - the state enum {IDLE, PACK, FLUSH}
- One sub-module, pack_gearbox: the acc/cnt shift-append datapath. It has append/emit/clear controls and flags word_ready and leftover count.
- The FSM, sop/eop tracking and the output register stay in data_pack.

## Test plan
- Symbols 01,02,03,04,05 (sop on first, eop on last), ready_in=1 → word 0x5080C101 (sop_out=1, bits_out=32), then word 0x00000000 (eop_out=1, bits_out=3). ready_out is low for exactly 1 cycle (FLUSH).
- Single symbol 7'h7F with sop and eop → data_out=0x0000007F, sop_out=1, eop_out=1, bits_out=7.
- 32 symbols (224 bits = 7 full words), ready_in=1 → 7 words, all with bits_out=32, eop only on word 7, and no FLUSH.
- ready_in=0 for 10 cycles with a word pending → data_out held stable and ready_out=0. On release, no loss or duplication.
- sop_in after 3 symbols without eop → drop_out pulses once, and the next word has sop_out=1 and contains only the new packet's bits.
- rst_n pulsed low mid-packet → all outputs 0 at the same time (asynchronously). The next packet packs correctly from bit 0.
